fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch controller sitting between the PC register and the IF/ID stage.
//   - Computes the next PC and drives the PC register's d/freeze inputs.
//   - Runs a req/ack read on instruction memory, which may have variable latency.
//   - Delivers instruction + PC+4 to decode with a valid flag.
//   - Handles decode stalls through a one-entry skid register, and branch redirects
//     that arrive while a memory read is still outstanding.
// PARAMETERS
//   WIDTH  32  address/instruction width; PC increments by 4 (mod 2^WIDTH)
// PORTS
//   clk          in   1      clock; all state updates on posedge
//   rst          in   1      reset, synchronous, active-high; also resets PC register and imem
//   pc_q         in   WIDTH  current PC (PC register output c)
//   pc_d         out  WIDTH  next PC (PC register input d)
//   pc_freeze    out  1      1 = PC register holds its value
//   branch_taken in   1      redirect request from EX; flush
//   branch_addr  in   WIDTH  redirect target
//   stall        in   1      decode cannot accept; held if_* outputs must stay stable
//   imem_req     out  1      read request, level; held until imem_ack
//   imem_addr    out  WIDTH  read address; stable while imem_req=1
//   imem_ack     in   1      read complete; imem_rdata valid this cycle (may be same cycle as req)
//   imem_rdata   in   WIDTH  instruction word
//   if_valid     out  1      if_instr/if_pc_plus4 hold a live instruction
//   if_instr     out  WIDTH  registered instruction to IF/ID
//   if_pc_plus4  out  WIDTH  registered fetch address + 4
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//     - state=FETCH, fetch_addr=0, if_valid=0, if_instr=0, if_pc_plus4=0, skid cleared.
//     - rst overrides everything, including mid-transaction.
//   Combinational outputs:
//     - pc_d = branch_taken ? branch_addr : fetch_addr+4.
//     - pc_freeze = ~(accept | branch_taken), where accept = FETCH & imem_ack.
//     - imem_req = (state==FETCH | state==DROP); imem_addr = fetch_addr.
//   States:
//     FETCH : request outstanding for fetch_addr.
//       - accept & ~branch_taken & slot_free, where slot_free = ~if_valid | ~stall:
//         if_instr<=rdata, if_pc_plus4<=fetch_addr+4, if_valid<=1, fetch_addr<=pc_d; stay FETCH.
//       - accept & ~branch_taken & ~slot_free: skid<=(rdata, fetch_addr+4),
//         fetch_addr<=pc_d; go HOLD.
//       - branch_taken & imem_ack: discard rdata, fetch_addr<=branch_addr; stay FETCH.
//       - branch_taken & ~imem_ack: fetch_addr unchanged; go DROP (old read must complete).
//       - No ack: if_valid<=if_valid & stall.
//     HOLD : req=0, PC frozen.
//       - ~stall: if_* <= skid, if_valid<=1; go FETCH.
//       - branch_taken: skid dropped, fetch_addr<=branch_addr; go FETCH.
//     DROP : req=1 with old fetch_addr; pc_q already holds the branch target.
//       - imem_ack: discard rdata, fetch_addr<=pc_q; go FETCH.
//       - A further branch_taken here only updates the PC; stay DROP.
//   Flush: branch_taken clears if_valid next cycle (flush has priority over stall) in every state.
//   Throughput: 1 instr/cycle when ack is combinational and stall=0. Latency req->if_valid = ack latency + 1.
//   imem_ack while imem_req=0 is ignored. PC wraps modulo 2^WIDTH (0xFFFFFFFC+4 -> 0).
// TESTING
//   1 Reset, ack tied 1, stall=0 -> imem_addr 0,4,8,... on consecutive cycles;
//     if_valid=1 from cycle 2; if_pc_plus4 = 4,8,12.
//   2 Ack delayed 3 cycles -> imem_req high and imem_addr=0 for 3 cycles;
//     pc_freeze=1 until ack; if_valid 1 cycle after ack.
//   3 stall=1 for 4 cycles with ack=1 -> 2nd word in skid, state HOLD, req=0;
//     if_instr unchanged; release -> skid word appears next cycle.
//   4 branch_taken to 0x100 while read of 0x8 outstanding -> DROP;
//     0x8 data discarded on ack; next imem_addr=0x100; if_valid=0 meanwhile.
//   5 branch_taken with stall=1 and if_valid=1 -> if_valid=0 next cycle; fetch resumes at target.
//   6 rst asserted in DROP and in HOLD -> next cycle state FETCH, imem_addr=0, if_valid=0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch controller bus: PC register, redirect/stall, instruction memory and IF/ID delivery.
// master = fetch_ctrl side, slave = pipeline/memory side.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             pc_freeze;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_addr;
  logic             stall;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             if_valid;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc_plus4;

  modport master (
    input  pc_q, branch_taken, branch_addr, stall, imem_ack, imem_rdata,
    output pc_d, pc_freeze, imem_req, imem_addr, if_valid, if_instr, if_pc_plus4
  );

  modport slave (
    output pc_q, branch_taken, branch_addr, stall, imem_ack, imem_rdata,
    input  pc_d, pc_freeze, imem_req, imem_addr, if_valid, if_instr, if_pc_plus4
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: next-PC selection, req/ack imem read, one-entry skid
// for decode stalls, and DROP state to retire a read orphaned by a branch redirect.
module fetch_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc4_q, skid_pc4_d;

  logic [WIDTH-1:0] fa_plus4;
  logic             accept;
  logic             slot_free;

  assign fa_plus4  = fa_q + WIDTH'(4);
  assign accept    = (state_q == FETCH) && bus.imem_ack;
  assign slot_free = ~vld_q | ~bus.stall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      fa_q         <= '0;
      vld_q        <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      fa_q         <= fa_d;
      vld_q        <= vld_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    fa_d         = fa_q;
    vld_d        = vld_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    case (state_q)
      FETCH: begin
        if (bus.branch_taken) begin
          vld_d = 1'b0;
          if (bus.imem_ack) fa_d = bus.branch_addr;
          else              state_d = DROP;
        end else if (bus.imem_ack) begin
          fa_d = fa_plus4;
          if (slot_free) begin
            instr_d = bus.imem_rdata;
            pc4_d   = fa_plus4;
            vld_d   = 1'b1;
          end else begin
            skid_instr_d = bus.imem_rdata;
            skid_pc4_d   = fa_plus4;
            state_d      = HOLD;
          end
        end else begin
          vld_d = vld_q & bus.stall;
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          vld_d   = 1'b0;
          fa_d    = bus.branch_addr;
          state_d = FETCH;
        end else if (~bus.stall) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          vld_d   = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        // A branch coinciding with the orphan ack wins: pc_q is one redirect behind.
        if (bus.branch_taken) begin
          vld_d = 1'b0;
          if (bus.imem_ack) begin
            fa_d    = bus.branch_addr;
            state_d = FETCH;
          end
        end else begin
          vld_d = vld_q & bus.stall;
          if (bus.imem_ack) begin
            fa_d    = bus.pc_q;
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs
  always_comb begin
    bus.pc_d        = bus.branch_taken ? bus.branch_addr : fa_plus4;
    bus.pc_freeze   = ~(accept | bus.branch_taken);
    bus.imem_req    = (state_q == FETCH) || (state_q == DROP);
    bus.imem_addr   = fa_q;
    bus.if_valid    = vld_q;
    bus.if_instr    = instr_q;
    bus.if_pc_plus4 = pc4_q;
  end

endmodule
